// File: rtl/l1_refill_stall_ctrl.sv
// Refill-port arbiter and pipeline stall/flush controller.
// Serves one I- or D-line refill at a time and freezes or bubbles stages around it.
module l1_refill_stall_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_miss,
    input  logic             dc_miss,
    input  logic             mem_ready,
    input  logic             load_use,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_sel,
    output logic [CNT_W-1:0] beat_idx,
    output logic             ic_fill_done,
    output logic             dc_fill_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_m_stall,
    output logic             m_wb_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             refill_err
);

    typedef enum logic [1:0] {
        IDLE,
        DREF,
        IREF,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic busy;
    logic last_beat;
    logic idle;

    assign busy      = (state_q == DREF) || (state_q == IREF);
    assign idle      = (state_q == IDLE);
    assign last_beat = busy && mem_ready && (beat_q == LAST);

    assign mem_req      = busy;
    assign mem_sel      = (state_q == DREF);
    assign beat_idx     = beat_q;
    assign refill_err   = err_q;
    // A reset landing on the final beat must not report a completed line.
    assign dc_fill_done = !rst && last_beat && (state_q == DREF);
    assign ic_fill_done = !rst && last_beat && (state_q == IREF);

    // Next-state, beat counting and inter-beat timeout tracking.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (dc_miss) begin
                    state_d = DREF;
                end else if (ic_miss) begin
                    state_d = IREF;
                end
            end
            DREF, IREF: begin
                if (mem_ready) begin
                    tmo_d = '0;
                    if (beat_q == LAST) begin
                        beat_d = '0;
                        // A pending I-miss rides straight in behind the D-line.
                        if ((state_q == DREF) && ic_miss) begin
                            state_d = IREF;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end else begin
                    if (tmo_q != TMO) begin
                        tmo_d = tmo_q + ONE;
                    end
                    if (tmo_q >= TMO - ONE) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hazard decode; a D-miss outranks a branch, which outranks an I-miss.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        ex_m_stall  = 1'b0;
        m_wb_stall  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if ((state_q == DREF) || (idle && dc_miss)) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_m_stall  = 1'b1;
            m_wb_stall  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if ((state_q == IREF) || (idle && ic_miss)) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // State and counter registers, synchronously cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_l1_refill_stall_ctrl.sv
// Directed bench for l1_refill_stall_ctrl with a cycle-level reference model.
// Literal checks in the stimulus pin the model against hand-derived values.
module tb_l1_refill_stall_ctrl;

    localparam int LW = 4;
    localparam int TO = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_miss = 1'b0;
    logic          dc_miss = 1'b0;
    logic          mem_ready = 1'b0;
    logic          load_use = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_req, mem_sel;
    logic [CW-1:0] beat_idx;
    logic          ic_fill_done, dc_fill_done;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_m_stall, m_wb_stall;
    logic          if_id_flush, id_ex_flush, refill_err;

    l1_refill_stall_ctrl #(
        .LINE_WORDS(LW),
        .TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ic_miss(ic_miss),
        .dc_miss(dc_miss),
        .mem_ready(mem_ready),
        .load_use(load_use),
        .branch_taken(branch_taken),
        .mem_req(mem_req),
        .mem_sel(mem_sel),
        .beat_idx(beat_idx),
        .ic_fill_done(ic_fill_done),
        .dc_fill_done(dc_fill_done),
        .pc_stall(pc_stall),
        .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall),
        .ex_m_stall(ex_m_stall),
        .m_wb_stall(m_wb_stall),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .refill_err(refill_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int bad  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port (-1 none, 0 I, 1 D), words moved,
    // cycles since the last word, the one-cycle release gap, sticky error.
    int owner = -1;
    int words = 0;
    int gap   = 0;
    bit gap_cycle = 1'b0;
    bit err   = 1'b0;
    bit valid = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            owner = -1;
            words = 0;
            gap = 0;
            gap_cycle = 1'b0;
            err = 1'b0;
            valid = 1'b1;
        end else if (valid) begin
            if (gap_cycle) begin
                gap_cycle = 1'b0;
            end else if (owner < 0) begin
                if (dc_miss) owner = 1;
                else if (ic_miss) owner = 0;
            end else if (mem_ready) begin
                words++;
                gap = 0;
                if (words == LW) begin
                    words = 0;
                    if (owner == 1 && ic_miss) begin
                        owner = 0;
                    end else begin
                        owner = -1;
                        gap_cycle = 1'b1;
                    end
                end
            end else begin
                gap++;
                if (gap >= TO) err = 1'b1;
            end
        end
    end

    initial forever begin
        bit free, fin;
        bit e_pc, e_ifs, e_ids, e_exs, e_wbs, e_iff, e_idf;
        @(negedge clk);
        if (valid) begin
            free = (owner < 0) && !gap_cycle;
            fin  = (owner >= 0) && mem_ready && (words == LW - 1);
            {e_pc, e_ifs, e_ids, e_exs, e_wbs, e_iff, e_idf} = '0;
            if (rst) begin
                e_pc = 1'b0;
            end else if (owner == 1 || (free && dc_miss)) begin
                {e_pc, e_ifs, e_ids, e_exs, e_wbs} = 5'b11111;
            end else if (branch_taken) begin
                {e_iff, e_idf} = 2'b11;
            end else if (owner == 0 || (free && ic_miss)) begin
                {e_pc, e_iff} = 2'b11;
            end else if (load_use) begin
                {e_pc, e_ifs, e_idf} = 3'b111;
            end
            chk("mem_req", mem_req, owner >= 0);
            chk("mem_sel", mem_sel, owner == 1);
            chk("beat_idx", beat_idx, (owner >= 0) ? words : 0);
            chk("dc_fill_done", dc_fill_done, !rst && fin && owner == 1);
            chk("ic_fill_done", ic_fill_done, !rst && fin && owner == 0);
            chk("refill_err", refill_err, err);
            chk("pc_stall", pc_stall, e_pc);
            chk("if_id_stall", if_id_stall, e_ifs);
            chk("id_ex_stall", id_ex_stall, e_ids);
            chk("ex_m_stall", ex_m_stall, e_exs);
            chk("m_wb_stall", m_wb_stall, e_wbs);
            chk("if_id_flush", if_id_flush, e_iff);
            chk("id_ex_flush", id_ex_flush, e_idf);
        end
    end

    task automatic cyc(input bit r, input bit dc, input bit ic, input bit rdy,
                       input bit lu, input bit br);
        @(posedge clk);
        #1;
        rst = r;
        dc_miss = dc;
        ic_miss = ic;
        mem_ready = rdy;
        load_use = lu;
        branch_taken = br;
        @(negedge clk);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 1);
        chk("L rst pc_stall", pc_stall, 0);
        chk("L rst if_id_flush", if_id_flush, 0);
        chk("L rst m_wb_stall", m_wb_stall, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("L rst mem_req", mem_req, 0);
        chk("L rst beat", beat_idx, 0);
        chk("L rst err", refill_err, 0);

        // D-line refill
        cyc(0, 1, 0, 0, 0, 0);
        chk("L d idle pc_stall", pc_stall, 1);
        chk("L d idle mem_req", mem_req, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 0, 0);
            chk("L d sel", mem_sel, 1);
            chk("L d beat", beat_idx, i);
            chk("L d wb_stall", m_wb_stall, 1);
            chk("L d done", dc_fill_done, i == 3);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("L d release req", mem_req, 0);
        chk("L d release pc", pc_stall, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // simultaneous misses: D then chained I
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 1, 0, 0);
            chk("L di sel", mem_sel, 1);
            chk("L di beat", beat_idx, i);
            chk("L di ddone", dc_fill_done, i == 3);
            chk("L di idone", ic_fill_done, 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            chk("L i req", mem_req, 1);
            chk("L i sel", mem_sel, 0);
            chk("L i beat", beat_idx, i);
            chk("L i pc_stall", pc_stall, 1);
            chk("L i if_id_flush", if_id_flush, 1);
            chk("L i wb_stall", m_wb_stall, 0);
            chk("L i done", ic_fill_done, i == 3);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("L i release req", mem_req, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // load-use in idle
        cyc(0, 0, 0, 0, 1, 0);
        chk("L lu pc", pc_stall, 1);
        chk("L lu if_id_stall", if_id_stall, 1);
        chk("L lu id_ex_flush", id_ex_flush, 1);
        chk("L lu ex_m", ex_m_stall, 0);
        chk("L lu wb", m_wb_stall, 0);

        // branch during I-refill
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 0, 1);
            chk("L br pc", pc_stall, 0);
            chk("L br if_id_flush", if_id_flush, 1);
            chk("L br id_ex_flush", id_ex_flush, 1);
            chk("L br beat", beat_idx, i);
            chk("L br done", ic_fill_done, i == 3);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // timeout
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 1, 0, 0, 0, 0);
            chk("L tmo err", refill_err, k >= 9);
            chk("L tmo req", mem_req, 1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 0, 0);
            chk("L tmo late beat", beat_idx, i);
            chk("L tmo late err", refill_err, 1);
            chk("L tmo late done", dc_fill_done, i == 3);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("L tmo held", refill_err, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("L tmo cleared", refill_err, 0);

        // reset at beat 2
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        chk("L mid rst beat", beat_idx, 2);
        chk("L mid rst done", dc_fill_done, 0);
        chk("L mid rst pc", pc_stall, 0);
        chk("L mid rst wb", m_wb_stall, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("L mid rst req", mem_req, 0);
        chk("L mid rst beat0", beat_idx, 0);
        chk("L mid rst pc0", pc_stall, 0);

        // reset on the final beat suppresses the done pulse
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        chk("L last rst beat", beat_idx, 3);
        chk("L last rst done", dc_fill_done, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("L last rst req", mem_req, 0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
